// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_pkg
//  Purpose  : Shared types, field widths, default timing values and address
//             helpers for the single-requester SDRAM controller.
//  Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

   localparam int BANK_W = 2;
   localparam int COL_W  = 13;
   localparam int DATA_W = 32;
   localparam int ADDR_W = BANK_W + COL_W;

   localparam int DEF_BANK_SWITCH_DELAY = 140;
   localparam int DEF_READ_LATENCY      = 2;
   localparam int DEF_REFRESH_INTERVAL  = 7800;
   localparam int DEF_REFRESH_CYCLES    = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SWITCH    = 3'd1,
      ST_ACCESS    = 3'd2,
      ST_READ_WAIT = 3'd3,
      ST_RESP      = 3'd4,
      ST_REFRESH   = 3'd5
   } state_e;

   typedef struct packed {
      logic [BANK_W-1:0] bank;
      logic [COL_W-1:0]  col;
   } addr_t;

   // Split a flat request address into its {bank, column} fields.
   function automatic addr_t split_addr(input logic [ADDR_W-1:0] addr);
      addr_t f;
      f.bank = addr[ADDR_W-1:COL_W];
      f.col  = addr[COL_W-1:0];
      return f;
   endfunction

   // Bits needed for a down-counter that is loaded with max_val-1; never 0.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_refresh_timer
//  Purpose  : Free-running refresh interval counter with a sticky request
//             flag. The flag stays set until the controller finishes a
//             refresh; expiries while pending collapse into one request.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_refresh_timer
   import sdram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,
   output logic pending_o
);

   localparam int               CNT_W  = cnt_width(REFRESH_INTERVAL);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             pending_q;

   // Interval down-counter plus sticky pending flag; a fresh expiry wins over
   // a clear in the same cycle so that request is not lost.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q     <= RELOAD;
         pending_q <= 1'b0;
      end else begin
         if (cnt_q == '0) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q - 1'b1;
            if (clear_i) begin
               pending_q <= 1'b0;
            end
         end
      end
   end

   assign pending_o = pending_q;

endmodule
`default_nettype wire

// File: rtl/sdram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_controller
//  Purpose  : Sequences single-requester accesses to a four-bank SDRAM block.
//             Charges a stall whenever the target bank differs from the open
//             bank, applies a fixed read latency and inserts periodic refresh.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_controller
   import sdram_pkg::*;
#(
   parameter int BANK_SWITCH_DELAY = DEF_BANK_SWITCH_DELAY,
   parameter int READ_LATENCY      = DEF_READ_LATENCY,
   parameter int REFRESH_INTERVAL  = DEF_REFRESH_INTERVAL,
   parameter int REFRESH_CYCLES    = DEF_REFRESH_CYCLES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_wr_en,
   output logic [BANK_W-1:0] mem_bank_address,
   output logic [COL_W-1:0]  mem_column_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wdata_oe,
   input  logic [DATA_W-1:0] mem_rdata
);

   // One counter serves both the bank-switch stall and the read latency.
   localparam int DLY_MAX = (BANK_SWITCH_DELAY > READ_LATENCY) ? BANK_SWITCH_DELAY : READ_LATENCY;
   localparam int DLY_W   = cnt_width(DLY_MAX);
   localparam int RFC_W   = cnt_width(REFRESH_CYCLES);

   localparam logic [DLY_W-1:0] SWITCH_LOAD = DLY_W'(BANK_SWITCH_DELAY - 1);
   localparam logic [DLY_W-1:0] READ_LOAD   = DLY_W'(READ_LATENCY - 1);
   localparam logic [RFC_W-1:0] RFC_LOAD    = RFC_W'(REFRESH_CYCLES - 1);

   state_e            state_q,      state_d;
   logic [DLY_W-1:0]  dly_q,        dly_d;
   logic [RFC_W-1:0]  rfc_q,        rfc_d;
   logic [BANK_W-1:0] open_bank_q,  open_bank_d;
   logic              open_valid_q, open_valid_d;
   logic              write_q,      write_d;
   addr_t             addr_q,       addr_d;
   logic [DATA_W-1:0] wdata_q,      wdata_d;
   logic [DATA_W-1:0] rdata_q,      rdata_d;

   addr_t             req_fields;
   logic              refresh_pending;
   logic              refresh_clear;

   assign req_fields = split_addr(req_addr);
   assign rsp_rdata  = rdata_q;

   sdram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_i   (refresh_clear),
      .pending_o (refresh_pending)
   );

   // State and datapath registers; reset drops any in-flight request.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         dly_q        <= '0;
         rfc_q        <= '0;
         open_bank_q  <= '0;
         open_valid_q <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         dly_q        <= dly_d;
         rfc_q        <= rfc_d;
         open_bank_q  <= open_bank_d;
         open_valid_q <= open_valid_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   // Next-state logic and Moore outputs; pins are idle outside ACCESS/READ_WAIT.
   always_comb begin
      state_d            = state_q;
      dly_d              = dly_q;
      rfc_d              = rfc_q;
      open_bank_d        = open_bank_q;
      open_valid_d       = open_valid_q;
      write_d            = write_q;
      addr_d             = addr_q;
      wdata_d            = wdata_q;
      rdata_d            = rdata_q;
      refresh_clear      = 1'b0;
      req_ready          = 1'b0;
      rsp_valid          = 1'b0;
      mem_wr_en          = 1'b0;
      mem_wdata_oe       = 1'b0;
      mem_bank_address   = '0;
      mem_column_address = '0;
      mem_wdata          = '0;

      case (state_q)
         ST_IDLE: begin
            // Refresh wins over a simultaneous request because ready is held low.
            req_ready = !refresh_pending;
            if (refresh_pending) begin
               rfc_d   = RFC_LOAD;
               state_d = ST_REFRESH;
            end else if (req_valid) begin
               write_d = req_write;
               addr_d  = req_fields;
               wdata_d = req_wdata;
               if (open_valid_q && (req_fields.bank == open_bank_q)) begin
                  state_d = ST_ACCESS;
               end else begin
                  dly_d   = SWITCH_LOAD;
                  state_d = ST_SWITCH;
               end
            end
         end

         ST_SWITCH: begin
            if (dly_q == '0) begin
               open_bank_d  = addr_q.bank;
               open_valid_d = 1'b1;
               state_d      = ST_ACCESS;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end

         ST_ACCESS: begin
            mem_bank_address   = addr_q.bank;
            mem_column_address = addr_q.col;
            mem_wr_en          = write_q;
            mem_wdata_oe       = write_q;
            mem_wdata          = wdata_q;
            if (write_q) begin
               state_d = ST_RESP;
            end else begin
               dly_d   = READ_LOAD;
               state_d = ST_READ_WAIT;
            end
         end

         ST_READ_WAIT: begin
            mem_bank_address   = addr_q.bank;
            mem_column_address = addr_q.col;
            if (dly_q == '0) begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end else begin
               dly_d = dly_q - 1'b1;
            end
         end

         ST_RESP: begin
            rsp_valid = 1'b1;
            state_d   = ST_IDLE;
         end

         ST_REFRESH: begin
            // Refresh closes the open row, so the next access is a miss.
            if (rfc_q == '0) begin
               refresh_clear = 1'b1;
               open_valid_d  = 1'b0;
               state_d       = ST_IDLE;
            end else begin
               rfc_d = rfc_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
